// File: rtl/nios_setup_oci_pkg.sv
// Shared constants and state encoding for the OCI data-compare-trace packer.
package nios_setup_oci_pkg;

  localparam int DCT_SYM_W    = 2;
  localparam int DCT_MAX_SYMS = 15;
  localparam int DCT_BUF_W    = 30;
  localparam int DCT_CNT_W    = 4;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    ENDED = 2'd2
  } dct_state_e;

endpackage

// File: rtl/nios_setup_nios2_gen2_0_cpu_oci_dct_packer_if.sv
// Valid/ready word channel from the DCT packer to the downstream consumer.
interface nios_setup_nios2_gen2_0_cpu_oci_dct_packer_if;
  import nios_setup_oci_pkg::*;

  logic                 dct_valid;
  logic                 dct_ready;
  logic [DCT_BUF_W-1:0] dct_buffer;
  logic [DCT_CNT_W-1:0] dct_count;

  modport master (output dct_valid, output dct_buffer, output dct_count, input dct_ready);
  modport slave  (input dct_valid, input dct_buffer, input dct_count, output dct_ready);
endinterface

// File: rtl/nios_setup_oci_dct_skid.sv
// One-entry output register: holds a packed word until the consumer takes it.
module nios_setup_oci_dct_skid
  import nios_setup_oci_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic [DCT_BUF_W-1:0] load_buf,
  input  logic [DCT_CNT_W-1:0] load_cnt,
  output logic                 space,
  nios_setup_nios2_gen2_0_cpu_oci_dct_packer_if.master dct_o
);

  logic                 valid_q, valid_d;
  logic [DCT_BUF_W-1:0] buf_q, buf_d;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: a load overwrites; otherwise hold until ready retires the word.
  always_comb begin
    space   = !valid_q || dct_o.dct_ready;
    valid_d = valid_q && !dct_o.dct_ready;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    if (load) begin
      valid_d = 1'b1;
      buf_d   = load_buf;
      cnt_d   = load_cnt;
    end
  end

  // Output word register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dct_o.dct_valid  = valid_q;
  assign dct_o.dct_buffer = buf_q;
  assign dct_o.dct_count  = cnt_q;

endmodule

// File: rtl/nios_setup_nios2_gen2_0_cpu_oci_dct_packer.sv
// DCT symbol packer with end-of-test drain sequencing.
// Optional: define NIOS_SETUP_DCT_DROP_CNT_EN to add a saturating drop_cnt port.
//
// state | meaning
// RUN   | normal packing; stop_req moves to DRAIN
// DRAIN | symbols ignored, partial word forced out, wait for empty
// ENDED | test_has_ended held; everything ignored until reset
module nios_setup_nios2_gen2_0_cpu_oci_dct_packer
  import nios_setup_oci_pkg::*;
#(
  parameter int SYM_W    = DCT_SYM_W,
  parameter int MAX_SYMS = DCT_MAX_SYMS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sym_valid,
  input  logic [SYM_W-1:0] sym,
  input  logic             flush,
  input  logic             stop_req,
  nios_setup_nios2_gen2_0_cpu_oci_dct_packer_if.master dct,
  output logic             overflow,
  output logic             test_ending,
  output logic             test_has_ended
`ifdef NIOS_SETUP_DCT_DROP_CNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);

  dct_state_e           state_q, state_d;
  logic [DCT_BUF_W-1:0] acc_q, acc_d, cand_acc, load_buf;
  logic [DCT_CNT_W-1:0] cnt_q, cnt_d, cand_cnt, load_cnt;
  logic                 run, draining, space, acc_full, accept, drop, flush_eff, load;

  nios_setup_oci_dct_skid u_skid (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_buf (load_buf),
    .load_cnt (load_cnt),
    .space    (space),
    .dct_o    (dct)
  );

  // Accumulator update, load decision and FSM next state.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    load      = 1'b0;
    load_buf  = acc_q;
    load_cnt  = cnt_q;
    run       = (state_q == RUN);
    draining  = (state_q == DRAIN);
    acc_full  = (cnt_q == DCT_CNT_W'(MAX_SYMS));
    drop      = run && sym_valid && acc_full && !space;
    accept    = run && sym_valid && !drop;
    flush_eff = (run && flush) || draining;
    cand_acc  = acc_q;
    cand_cnt  = cnt_q;
    if (accept && !acc_full) begin
      cand_acc = {acc_q[DCT_BUF_W-SYM_W-1:0], sym};
      cand_cnt = cnt_q + DCT_CNT_W'(1);
    end

    if (acc_full) begin
      // A full accumulator only moves when the output slot frees; a symbol
      // arriving in that cycle starts the next word.
      if (space) begin
        load  = 1'b1;
        acc_d = accept ? {{(DCT_BUF_W-SYM_W){1'b0}}, sym} : '0;
        cnt_d = accept ? DCT_CNT_W'(1) : '0;
      end
    end else if ((cand_cnt == DCT_CNT_W'(MAX_SYMS)) || (flush_eff && cand_cnt != '0)) begin
      if (space) begin
        load     = 1'b1;
        load_buf = cand_acc;
        load_cnt = cand_cnt;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = cand_acc;
        cnt_d = cand_cnt;
      end
    end else begin
      acc_d = cand_acc;
      cnt_d = cand_cnt;
    end

    case (state_q)
      RUN:     if (stop_req) state_d = DRAIN;
      DRAIN:   if (cnt_q == '0 && !dct.dct_valid) state_d = ENDED;
      ENDED:   state_d = ENDED;
      default: state_d = RUN;
    endcase
  end

  // FSM and accumulator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign test_ending    = (state_q == DRAIN);
  assign test_has_ended = (state_q == ENDED);

`ifdef NIOS_SETUP_DCT_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  // Saturating count of dropped symbols.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) drop_cnt_q <= '0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
  assign overflow = (drop_cnt_q != 8'd0);
`else
  logic overflow_q, overflow_d;

  // Sticky flag set by any dropped symbol.
  always_comb begin
    overflow_d = overflow_q | drop;
  end

  // Overflow register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) overflow_q <= 1'b0;
    else          overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`endif

endmodule

// File: tb/tb_nios_setup_nios2_gen2_0_cpu_oci_dct_packer.sv
// Directed bench for the DCT packer.
module tb_nios_setup_nios2_gen2_0_cpu_oci_dct_packer;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       sym_valid = 1'b0;
  logic [1:0] sym = 2'b00;
  logic       flush = 1'b0;
  logic       stop_req = 1'b0;
  logic       overflow, test_ending, test_has_ended;
`ifdef NIOS_SETUP_DCT_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif
  int n_assert = 0;
  int n_fail = 0;

  nios_setup_nios2_gen2_0_cpu_oci_dct_packer_if dct_if ();

  nios_setup_nios2_gen2_0_cpu_oci_dct_packer dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sym_valid      (sym_valid),
    .sym            (sym),
    .flush          (flush),
    .stop_req       (stop_req),
    .dct            (dct_if.master),
    .overflow       (overflow),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
`ifdef NIOS_SETUP_DCT_DROP_CNT_EN
    ,
    .drop_cnt       (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [1:0] s);
    sym_valid = 1'b1;
    sym = s;
    tick();
    sym_valid = 1'b0;
  endtask

  task automatic chk_word(input string tag, input logic v, input logic [29:0] b, input logic [3:0] c);
    chk({tag, "_valid"}, {31'b0, dct_if.dct_valid}, {31'b0, v});
    if (v) begin
      chk({tag, "_buf"}, {2'b0, dct_if.dct_buffer}, {2'b0, b});
      chk({tag, "_cnt"}, {28'b0, dct_if.dct_count}, {28'b0, c});
    end
  endtask

  initial begin
    dct_if.dct_ready = 1'b1;
    // reset state
    tick(); tick();
    chk("rst_valid", {31'b0, dct_if.dct_valid}, 32'd0);
    chk("rst_buf", {2'b0, dct_if.dct_buffer}, 32'd0);
    chk("rst_cnt", {28'b0, dct_if.dct_count}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_ending", {31'b0, test_ending}, 32'd0);
    chk("rst_ended", {31'b0, test_has_ended}, 32'd0);
    reset_n = 1'b1;
    tick();

    // full word of 15 x 01
    for (int i = 0; i < 14; i++) send(2'b01);
    chk_word("full_pre", 1'b0, 30'h0, 4'd0);
    send(2'b01);
    chk_word("full", 1'b1, 30'h15555555, 4'd15);
    tick();
    chk_word("full_drop", 1'b0, 30'h0, 4'd0);

    // partial word via flush
    send(2'b11); send(2'b10); send(2'b01);
    chk_word("part_pre", 1'b0, 30'h0, 4'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk_word("part", 1'b1, 30'h39, 4'd3);
    tick();
    chk_word("part_done", 1'b0, 30'h0, 4'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk_word("flush_empty", 1'b0, 30'h0, 4'd0);

    // backpressure and overflow
    dct_if.dct_ready = 1'b0;
    for (int i = 0; i < 15; i++) send(2'b10);
    chk_word("bp_first", 1'b1, 30'h2AAAAAAA, 4'd15);
    for (int i = 0; i < 15; i++) send(2'b11);
    chk_word("bp_hold", 1'b1, 30'h2AAAAAAA, 4'd15);
    chk("bp_ovf_pre", {31'b0, overflow}, 32'd0);
    send(2'b01);
    chk("bp_ovf", {31'b0, overflow}, 32'd1);
`ifdef NIOS_SETUP_DCT_DROP_CNT_EN
    chk("bp_dropcnt", {24'b0, drop_cnt}, 32'd1);
`endif
    chk_word("bp_hold2", 1'b1, 30'h2AAAAAAA, 4'd15);
    dct_if.dct_ready = 1'b1;
    tick();
    chk_word("bp_second", 1'b1, 30'h3FFFFFFF, 4'd15);
    tick();
    chk_word("bp_empty", 1'b0, 30'h0, 4'd0);
    chk("bp_ovf_sticky", {31'b0, overflow}, 32'd1);

    // 15th symbol with flush, then a 16th symbol
    for (int i = 0; i < 14; i++) send(2'b01);
    flush = 1'b1; send(2'b10); flush = 1'b0;
    chk_word("f15", 1'b1, 30'h15555556, 4'd15);
    send(2'b11);
    chk_word("f15_single", 1'b0, 30'h0, 4'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk_word("f16", 1'b1, 30'h3, 4'd1);
    tick();

    // end-of-test drain with a held word
    dct_if.dct_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(2'b01);
    stop_req = 1'b1; tick(); stop_req = 1'b0;
    chk("drn_ending0", {31'b0, test_ending}, 32'd1);
    chk_word("drn_w0", 1'b0, 30'h0, 4'd0);
    sym_valid = 1'b1; sym = 2'b11;
    tick();
    chk_word("drn_w1", 1'b1, 30'h155, 4'd5);
    tick(); tick(); tick();
    chk_word("drn_hold", 1'b1, 30'h155, 4'd5);
    chk("drn_ending1", {31'b0, test_ending}, 32'd1);
    chk("drn_ended0", {31'b0, test_has_ended}, 32'd0);
    dct_if.dct_ready = 1'b1;
    tick();
    chk_word("drn_xfer", 1'b0, 30'h0, 4'd0);
    chk("drn_ending2", {31'b0, test_ending}, 32'd1);
    tick();
    chk("drn_ending3", {31'b0, test_ending}, 32'd0);
    chk("drn_ended1", {31'b0, test_has_ended}, 32'd1);
    flush = 1'b1;
    for (int i = 0; i < 16; i++) tick();
    flush = 1'b0; sym_valid = 1'b0;
    chk_word("end_ignored", 1'b0, 30'h0, 4'd0);
    chk("end_sticky", {31'b0, test_has_ended}, 32'd1);

    // async reset mid-word
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    chk("rst2_ended", {31'b0, test_has_ended}, 32'd0);
    chk("rst2_ovf", {31'b0, overflow}, 32'd0);
    dct_if.dct_ready = 1'b0;
    for (int i = 0; i < 22; i++) send(2'b10);
    chk_word("mid_held", 1'b1, 30'h2AAAAAAA, 4'd15);
    #3 reset_n = 1'b0;
    #1;
    chk("async_valid", {31'b0, dct_if.dct_valid}, 32'd0);
    chk("async_buf", {2'b0, dct_if.dct_buffer}, 32'd0);
    chk("async_cnt", {28'b0, dct_if.dct_count}, 32'd0);
    #2 reset_n = 1'b1;
    dct_if.dct_ready = 1'b1;
    tick(); tick();
    flush = 1'b1; tick(); flush = 1'b0;
    tick();
    chk_word("post_rst", 1'b0, 30'h0, 4'd0);
    chk("post_rst_ending", {31'b0, test_ending}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/nios_setup_nios2_gen2_0_cpu_oci_dct_packer.md
Name: nios_setup_nios2_gen2_0_cpu_oci_dct_packer

Overview:
- Upstream feeder of the OCI debug test bench. Packs 2-bit data-compare-trace (DCT) symbols from the OCI trace logic into a 30-bit word with a 4-bit symbol count.
- Drives dct_buffer/dct_count to the downstream consumer through a valid/ready handshake.
- Sequences test_ending/test_has_ended around an end-of-test drain.

Parameters:
- SYM_W, 2: bits per trace symbol.
- MAX_SYMS, 15: symbols per packed word; SYM_W*MAX_SYMS = 30.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sym_valid  in  1  trace symbol present this cycle
- sym  in  2  trace symbol
- flush  in  1  emit a partial word if count>0
- stop_req  in  1  end-of-test request (level, sampled each cycle)
- dct_ready  in  1  downstream accepts word
- dct_valid  out  1  output word valid
- dct_buffer  out  30  packed symbols; newest in bits [1:0]
- dct_count  out  4  symbols in dct_buffer, 1..15 when valid
- overflow  out  1  sticky; a symbol was dropped
- test_ending  out  1  drain in progress
- test_has_ended  out  1  drain complete, sticky until reset

Behaviour:
- Reset (async assert, sync deassert): all outputs 0; accumulator, count and FSM cleared.
- Accumulator acc[29:0], acc_cnt[3:0]. Accepted symbol: acc <= {acc[27:0], sym}; acc_cnt+1.
- Output register (dct_valid/dct_buffer/dct_count) is a one-entry skid.
  - Load when acc_cnt reaches 15, or on flush with acc_cnt>0, and only if the output register is empty or being drained this cycle (dct_valid & dct_ready).
  - On load, the accumulator restarts. A same-cycle accepted symbol becomes acc={28'b0,sym}, acc_cnt=1.
  - Load therefore includes the current-cycle symbol when it completes the 15th slot: one cycle of latency from the 15th symbol to dct_valid.
- Handshake: dct_valid holds, with dct_buffer/dct_count stable, until dct_ready. Transfer happens on dct_valid & dct_ready.
- Full stall: acc_cnt==15 and the output register is occupied and not draining:
  - an incoming sym_valid is dropped;
  - overflow <= 1 (sticky);
  - the accumulator is unchanged.
- flush with acc_cnt==0: no action. flush and a 15th symbol in the same cycle: a single load of 15.
- FSM:
  - RUN: normal operation. stop_req -> DRAIN.
  - DRAIN: test_ending=1. Symbols are ignored. An internal flush is forced each cycle. When acc_cnt==0 and dct_valid==0 -> ENDED.
  - ENDED: test_ending=0, test_has_ended=1. Inputs are ignored. Exit only via reset.
- stop_req in the same cycle as a symbol: the symbol is accepted, then the FSM enters DRAIN.
- Reset mid-word or mid-drain: partial data is discarded; no word is emitted.

Optional Feature:
- Macro: NIOS_SETUP_DCT_DROP_CNT_EN.
- Defined: adds output drop_cnt [7:0], counting dropped symbols. It saturates at 255 and resets to 0. overflow = (drop_cnt != 0).
- Undefined: port absent; overflow is a 1-bit sticky flag only.

Decomposition:
- Shared package nios_setup_oci_pkg:
  - DCT_SYM_W=2, DCT_MAX_SYMS=15, DCT_BUF_W=30, DCT_CNT_W=4;
  - typedef dct_state_e {RUN, DRAIN, ENDED}.
- One sub-module: nios_setup_oci_dct_skid, the one-entry output register with valid/ready.
- Packing and FSM stay in the top.

Test Plan:
- Reset, then 15 symbols 2'b01 with dct_ready=1 -> one cycle later dct_valid=1, dct_buffer=30'h15555555, dct_count=15; valid drops after one cycle.
- 3 symbols 2'b11, 2'b10, 2'b01, then flush -> dct_buffer=30'h39, dct_count=3.
- dct_ready=0, feed 31 symbols -> first word held stable; accumulator full at 15; 31st symbol dropped; overflow=1; drop_cnt=1 if the macro is defined.
- 15th symbol and flush in the same cycle, plus a 16th symbol in the next cycle -> exactly one word of count 15, then acc_cnt=1.
- 5 symbols then stop_req, with dct_ready low for 4 cycles -> test_ending=1 through the hold; word count 5 transfers; test_has_ended=1 on the following cycle; later symbols ignored.
- Assert reset_n low mid-word (acc_cnt=7) asynchronously between clock edges -> all outputs 0 immediately; no word emitted after release.
